// File: rtl/pkt_pkg.sv
// Shared packet definitions: default field widths, counter width and the packet payload struct.
package pkt_pkg;

    localparam int unsigned ADDR_WD_DEF = 7;
    localparam int unsigned DATA_WD_DEF = 32;
    localparam int unsigned CNT_WD      = 16;

    typedef struct packed {
        logic [ADDR_WD_DEF-1:0] addr;
        logic [DATA_WD_DEF-1:0] data;
    } pkt_t;

endpackage

// File: rtl/pkt_if.sv
// Packet valid/ready bus; master drives the packet, slave returns ready.
interface pkt_if #(
    parameter int unsigned ADDR_WD = pkt_pkg::ADDR_WD_DEF,
    parameter int unsigned DATA_WD = pkt_pkg::DATA_WD_DEF
) ();

    logic               vld;
    logic               rdy;
    logic [ADDR_WD-1:0] addr;
    logic [DATA_WD-1:0] data;

    modport master (output vld, output addr, output data, input  rdy);
    modport slave  (input  vld, input  addr, input  data, output rdy);

endinterface

// File: rtl/pkt_rx_ram.sv
// Packet storage: one synchronous write port, one asynchronous read port, contents not reset.
module pkt_rx_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 39
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/pkt_rx_fifo.sv
// Receive packet FIFO without input backpressure; overflowing packets are dropped and counted.
module pkt_rx_fifo
    import pkt_pkg::*;
#(
    parameter int unsigned ADDR_WD = ADDR_WD_DEF,
    parameter int unsigned DATA_WD = DATA_WD_DEF,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pkt_if.slave                     in_if,
    pkt_if.master                    out_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CNT_WD-1:0]        drop_cnt,
    input  logic                     ovf_clr
);

    localparam int unsigned PTR_WD = $clog2(DEPTH);
    localparam int unsigned LVL_WD = PTR_WD + 1;
    localparam int unsigned ENT_WD = ADDR_WD + DATA_WD;

    logic [PTR_WD-1:0]  r_wr_ptr;
    logic [PTR_WD-1:0]  r_rd_ptr;
    logic [LVL_WD-1:0]  r_level;
    logic               r_out_vld;
    logic [ADDR_WD-1:0] r_out_addr;
    logic [DATA_WD-1:0] r_out_data;
    logic               r_ovf;
    logic [CNT_WD-1:0]  r_drop_cnt;

    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [PTR_WD-1:0]  w_rd_nxt;
    logic [LVL_WD-1:0]  w_lvl_rem;
    logic [LVL_WD-1:0]  w_lvl_nxt;
    logic [ENT_WD-1:0]  w_rdata;
    logic [ADDR_WD-1:0] w_rd_addr;
    logic [DATA_WD-1:0] w_rd_data;

    // Full/empty come from the level count so pointer equality is never ambiguous.
    assign w_full    = (r_level == LVL_WD'(DEPTH));
    assign w_pop     = (r_level != '0) & out_if.rdy;
    assign w_push    = in_if.vld & (~w_full | w_pop);
    assign w_drop    = in_if.vld & ~w_push;
    assign w_rd_nxt  = r_rd_ptr + PTR_WD'(w_pop);
    assign w_lvl_rem = r_level - LVL_WD'(w_pop);
    assign w_lvl_nxt = w_lvl_rem + LVL_WD'(w_push);

    pkt_rx_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_WD)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_push),
        .i_waddr   (r_wr_ptr),
        .i_wdata   ({in_if.addr, in_if.data}),
        .i_raddr   (w_rd_nxt),
        .o_rdata_c (w_rdata)
    );

    assign {w_rd_addr, w_rd_data} = w_rdata;

    // Head register: loads the incoming packet when it becomes the only entry, else the next stored one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_vld  <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else begin
            r_rd_ptr  <= w_rd_nxt;
            r_level   <= w_lvl_nxt;
            r_out_vld <= (w_lvl_nxt != '0);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WD'(1);
            if (w_push && (w_lvl_rem == '0)) begin
                r_out_addr <= in_if.addr;
                r_out_data <= in_if.data;
            end else if (w_pop && (w_lvl_rem != '0)) begin
                r_out_addr <= w_rd_addr;
                r_out_data <= w_rd_data;
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr)                     r_drop_cnt <= CNT_WD'(1);
            else if (r_drop_cnt != '1)       r_drop_cnt <= r_drop_cnt + CNT_WD'(1);
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign in_if.rdy   = 1'b1;
    assign out_if.vld  = r_out_vld;
    assign out_if.addr = r_out_addr;
    assign out_if.data = r_out_data;
    assign level       = r_level;
    assign ovf         = r_ovf;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_pkt_rx_fifo.sv
// Bench for pkt_rx_fifo: directed and random steps checked against a queue-based packet model.
module tb_pkt_rx_fifo;
    import pkt_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        ovf_clr;
    logic [4:0]  level;
    logic        ovf;
    logic [15:0] drop_cnt;

    pkt_if #(.ADDR_WD(ADDR_WD_DEF), .DATA_WD(DATA_WD_DEF)) in_if ();
    pkt_if #(.ADDR_WD(ADDR_WD_DEF), .DATA_WD(DATA_WD_DEF)) out_if ();

    pkt_rx_fifo #(
        .ADDR_WD (ADDR_WD_DEF),
        .DATA_WD (DATA_WD_DEF),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_if    (in_if),
        .out_if   (out_if),
        .level    (level),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pkt_t        q[$];
    bit          m_ovf;
    int unsigned m_cnt;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vld"},   64'(out_if.vld), 64'(q.size() != 0));
        chk({tag, ".level"}, 64'(level),      64'(q.size()));
        chk({tag, ".ovf"},   64'(ovf),        64'(m_ovf));
        chk({tag, ".drop"},  64'(drop_cnt),   64'(m_cnt));
        if (q.size() != 0) begin
            chk({tag, ".addr"}, 64'(out_if.addr), 64'(q[0].addr));
            chk({tag, ".data"}, 64'(out_if.data), 64'(q[0].data));
        end
    endtask

    // One clock: drive at negedge, advance the model across the edge, compare just after it.
    task automatic step(input bit vld, input logic [6:0] a, input logic [31:0] d,
                        input bit rdy, input bit clr, input bit do_chk, input string tag);
        bit pop, push;
        @(negedge clk);
        in_if.vld   = vld;
        in_if.addr  = a;
        in_if.data  = d;
        out_if.rdy  = rdy;
        ovf_clr     = clr;
        pop  = (q.size() != 0) && rdy;
        push = vld && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back('{addr: a, data: d});
        if (vld && !push) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt == 32'hFFFF) ? m_cnt : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (do_chk) check_model(tag);
    endtask

    task automatic idle(input bit rdy, input bit clr, input string tag);
        step(1'b0, 7'h0, 32'h0, rdy, clr, 1'b1, tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_ovf    = 1'b0;
        m_cnt    = 0;
        rst_n      = 1'b0;
        in_if.vld  = 1'b0;
        in_if.addr = '0;
        in_if.data = '0;
        out_if.rdy = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld",   64'(out_if.vld),  64'(0));
        chk("rst.level", 64'(level),       64'(0));
        chk("rst.ovf",   64'(ovf),         64'(0));
        chk("rst.drop",  64'(drop_cnt),    64'(0));
        chk("rst.addr",  64'(out_if.addr), 64'(0));
        chk("rst.data",  64'(out_if.data), 64'(0));
        chk("in_rdy",    64'(in_if.rdy),   64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Single packet through an empty FIFO.
        step(1'b1, 7'h05, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, "single_push");
        chk("single.vld",   64'(out_if.vld),  64'(1));
        chk("single.data",  64'(out_if.data), 64'(32'hDEADBEEF));
        chk("single.addr",  64'(out_if.addr), 64'(7'h05));
        chk("single.lvl1",  64'(level),       64'(1));
        idle(1'b1, 1'b0, "single_pop");
        chk("single.lvl0",  64'(level),       64'(0));

        // Fill, overflow by one, drain.
        for (int i = 0; i < 16; i++)
            step(1'b1, 7'(i), 32'($urandom), 1'b0, 1'b0, 1'b1, "fill");
        chk("fill.level", 64'(level), 64'(16));
        chk("fill.ovf",   64'(ovf),   64'(0));
        step(1'b1, 7'h7F, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b1, "drop17");
        chk("drop17.ovf",  64'(ovf),      64'(1));
        chk("drop17.cnt",  64'(drop_cnt), 64'(1));
        for (int i = 0; i < 16; i++) idle(1'b1, 1'b0, "drain");
        chk("drain.level", 64'(level), 64'(0));

        // Full with simultaneous pop accepts the push.
        idle(1'b0, 1'b1, "clr0");
        for (int i = 0; i < 16; i++)
            step(1'b1, 7'(i + 32), 32'($urandom), 1'b0, 1'b0, 1'b1, "fill2");
        step(1'b1, 7'h11, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, "full_pop");
        chk("full_pop.level", 64'(level),    64'(16));
        chk("full_pop.drop",  64'(drop_cnt), 64'(0));
        for (int i = 0; i < 15; i++) idle(1'b1, 1'b0, "drain2");
        chk("full_pop.last", 64'(out_if.data), 64'(32'hCAFEF00D));
        idle(1'b1, 1'b0, "drain2_last");

        // Back-to-back stream across pointer wrap with random acceptance.
        for (int i = 0; i < 40; i++)
            step(1'b1, 7'(i), 32'(i),
                 (q.size() == DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 1'b1, "wrap");
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1, 1'b0, "wrap_drain");
        chk("wrap.drop",  64'(drop_cnt), 64'(0));
        chk("wrap.level", 64'(level),    64'(0));

        // Random traffic including overflow and clears.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 7'($urandom), 32'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0), 1'b1, "rand");

        // Overflow clear against a drop, then counter saturation.
        for (int i = 0; i < 20; i++) idle(1'b1, 1'b1, "pre_clr");
        for (int i = 0; i < 16; i++)
            step(1'b1, 7'(i), 32'($urandom), 1'b0, 1'b0, 1'b1, "fill3");
        step(1'b1, 7'h01, 32'h1, 1'b0, 1'b1, 1'b1, "clr_drop");
        chk("clr_drop.ovf", 64'(ovf),      64'(1));
        chk("clr_drop.cnt", 64'(drop_cnt), 64'(1));
        idle(1'b0, 1'b1, "clr_only");
        chk("clr_only.ovf", 64'(ovf),      64'(0));
        chk("clr_only.cnt", 64'(drop_cnt), 64'(0));
        for (int i = 0; i < 65535; i++)
            step(1'b1, 7'($urandom), 32'($urandom), 1'b0, 1'b0, 1'b0, "sat_fill");
        check_model("sat_reach");
        chk("sat.reach", 64'(drop_cnt), 64'(16'hFFFF));
        step(1'b1, 7'h02, 32'h2, 1'b0, 1'b0, 1'b1, "sat_hold");
        chk("sat.hold", 64'(drop_cnt), 64'(16'hFFFF));
        chk("sat.ovf",  64'(ovf),      64'(1));

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 16; i++) idle(1'b1, 1'b1, "pre_rst");
        for (int i = 0; i < 5; i++)
            step(1'b1, 7'(i + 64), 32'($urandom), 1'b0, 1'b0, 1'b1, "pre_rst_fill");
        chk("pre_rst.level", 64'(level), 64'(5));
        @(negedge clk);
        #2;
        in_if.vld = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst.vld",   64'(out_if.vld), 64'(0));
        chk("mid_rst.level", 64'(level),      64'(0));
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b1, 7'h2A, 32'h12345678, 1'b0, 1'b0, 1'b1, "post_rst");
        chk("post_rst.data",  64'(out_if.data), 64'(32'h12345678));
        chk("post_rst.level", 64'(level),       64'(1));
        idle(1'b1, 1'b0, "post_rst_pop");
        chk("post_rst.empty", 64'(out_if.vld),  64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
